// File: rtl/rover_sw_event_ctrl.sv
// -----------------------------------------------------------------------------
// rover_sw_event_ctrl
//
// Interrupt-driven service controller for the rover's 4-bit switch PIO.
// After reset it writes the PIO irq_mask. On each PIO interrupt it:
//   - reads edge_capture;
//   - clears edge_capture;
//   - reads the switch levels;
//   - queues an {edges, levels} event into a small FIFO.
// A hold-off window after every pass absorbs mechanical switch bounce.
//
// Parameters:
//   IRQ_MASK    value written to PIO irq_mask (address 2) after reset
//   HOLDOFF     idle cycles enforced after each service pass (0 = none)
//   FIFO_DEPTH  event FIFO entries, power of 2, >= 2
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   enable           1 = service interrupts; 0 = finish the current pass, then idle
//   pio_address      PIO Avalon-MM address (registered)
//   pio_chipselect   PIO select (registered)
//   pio_write_n      PIO write strobe, active-low (registered)
//   pio_writedata    PIO write data (registered)
//   pio_readdata     PIO read data, read latency 1
//   pio_irq          PIO interrupt request
//   evt_valid        event FIFO non-empty
//   evt_ready        consumer pop request
//   evt_edges        head entry: captured edge bits
//   evt_level        head entry: switch levels
//   overflow         sticky flag: an event was dropped on a full FIFO
//   clear_overflow   synchronous clear of overflow
// -----------------------------------------------------------------------------
module rover_sw_event_ctrl #(
    parameter logic [3:0] IRQ_MASK   = 4'hF,
    parameter int         HOLDOFF    = 16,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    input  logic [31:0] pio_readdata,
    input  logic        pio_irq,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [3:0]  evt_edges,
    output logic [3:0]  evt_level,
    output logic        overflow,
    input  logic        clear_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_RD_EDGE_A = 3'd2,
        ST_RD_EDGE_D = 3'd3,
        ST_CLR       = 3'd4,
        ST_RD_LVL_A  = 3'd5,
        ST_RD_LVL_D  = 3'd6,
        ST_HOLD      = 3'd7
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic           init_issued_r;
    logic [HW-1:0]  hold_cnt_r;
    logic [3:0]     edge_r;

    logic [1:0]     address_r;
    logic           chipselect_r;
    logic           write_n_r;
    logic [31:0]    writedata_r;
    logic [1:0]     address_s;
    logic           chipselect_s;
    logic           write_n_s;
    logic [31:0]    writedata_s;

    logic [7:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic [CW-1:0]  count_s;
    logic           evt_valid_r;
    logic           overflow_r;

    logic           push_req_s;
    logic           pop_s;
    logic           full_s;
    logic           push_s;
    logic           drop_s;

    // Only the four switch bits of the PIO read bus carry information.
    logic           unused_readdata_s;
    assign unused_readdata_s = ^pio_readdata[31:4];

    // Next-state logic for the service sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            // INIT stays for one extra cycle so its bus write is visible
            // in the first cycle after reset release.
            ST_INIT: begin
                if (init_issued_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (pio_irq && enable) begin
                    state_s = ST_RD_EDGE_A;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_EDGE_A: state_s = ST_RD_EDGE_D;
            ST_RD_EDGE_D: state_s = ST_CLR;
            ST_CLR:       state_s = ST_RD_LVL_A;
            ST_RD_LVL_A:  state_s = ST_RD_LVL_D;
            ST_RD_LVL_D: begin
                if (HOLDOFF > 0) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: state_s = ST_INIT;
        endcase
    end

    // Bus values for the upcoming state, registered so bus pins track the state.
    always_comb begin
        address_s    = 2'd0;
        chipselect_s = 1'b0;
        write_n_s    = 1'b1;
        writedata_s  = 32'd0;
        case (state_s)
            ST_INIT: begin
                address_s    = ADDR_MASK;
                chipselect_s = 1'b1;
                write_n_s    = 1'b0;
                writedata_s  = {28'd0, IRQ_MASK};
            end
            ST_RD_EDGE_A: begin
                address_s    = ADDR_EDGE;
                chipselect_s = 1'b1;
            end
            ST_RD_EDGE_D: begin
                address_s    = ADDR_EDGE;
            end
            ST_CLR: begin
                address_s    = ADDR_EDGE;
                chipselect_s = 1'b1;
                write_n_s    = 1'b0;
                writedata_s  = 32'd0;
            end
            ST_RD_LVL_A: begin
                address_s    = ADDR_DATA;
                chipselect_s = 1'b1;
            end
            default: begin
                address_s    = 2'd0;
                chipselect_s = 1'b0;
                write_n_s    = 1'b1;
                writedata_s  = 32'd0;
            end
        endcase
    end

    // Sequencer state, hold-off counter, edge sample and registered bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_INIT;
            init_issued_r <= 1'b0;
            hold_cnt_r    <= '0;
            edge_r        <= 4'd0;
            address_r     <= 2'd0;
            chipselect_r  <= 1'b0;
            write_n_r     <= 1'b1;
            writedata_r   <= 32'd0;
        end else begin
            state_r       <= state_s;
            init_issued_r <= init_issued_r | (state_r == ST_INIT);
            if (state_r == ST_HOLD) begin
                hold_cnt_r <= hold_cnt_r + HW'(1);
            end else begin
                hold_cnt_r <= '0;
            end
            if (state_r == ST_RD_EDGE_D) begin
                edge_r <= pio_readdata[3:0];
            end else begin
                edge_r <= edge_r;
            end
            address_r    <= address_s;
            chipselect_r <= chipselect_s;
            write_n_r    <= write_n_s;
            writedata_r  <= writedata_s;
        end
    end

    // The level read returns during RD_LVL_D and is pushed together with the
    // edge sample; a pass with no captured edges is spurious and pushes nothing.
    assign push_req_s = (state_r == ST_RD_LVL_D) && (edge_r != 4'd0);
    assign pop_s      = (count_r != '0) && evt_ready;
    assign full_s     = (count_r == CW'(FIFO_DEPTH));
    assign push_s     = push_req_s && (!full_s || pop_s);
    assign drop_s     = push_req_s && full_s && !pop_s;

    // Next FIFO occupancy.
    always_comb begin
        count_s = count_r;
        if (push_s && !pop_s) begin
            count_s = count_r + CW'(1);
        end else if (!push_s && pop_s) begin
            count_s = count_r - CW'(1);
        end else begin
            count_s = count_r;
        end
    end

    // Event FIFO storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'd0;
            end
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            evt_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {edge_r, pio_readdata[3:0]};
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r     <= count_s;
            evt_valid_r <= (count_s != '0);
            // A drop in the same cycle as a clear request leaves the flag set.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clear_overflow) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign pio_address    = address_r;
    assign pio_chipselect = chipselect_r;
    assign pio_write_n    = write_n_r;
    assign pio_writedata  = writedata_r;
    assign evt_valid      = evt_valid_r;
    assign evt_edges      = mem_r[rd_ptr_r][7:4];
    assign evt_level      = mem_r[rd_ptr_r][3:0];
    assign overflow       = overflow_r;

endmodule

// File: tb/tb_rover_sw_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rover_sw_event_ctrl
//
// Bench for rover_sw_event_ctrl. A small behavioural PIO model provides:
//   - any-edge capture (edge_capture);
//   - an irq_mask register;
//   - a registered read port.
// The model has its own reset, so pending edges survive a controller reset.
// Event expectations come from a stimulus table; multi-cycle corner cases
// are written out by hand.
// -----------------------------------------------------------------------------
module tb_rover_sw_event_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata;
    logic        pio_irq;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_edges;
    logic [3:0]  evt_level;
    logic        overflow;
    logic        clear_overflow;

    always #5 clk = ~clk;

    rover_sw_event_ctrl #(
        .IRQ_MASK   (4'hF),
        .HOLDOFF    (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .pio_irq        (pio_irq),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_edges      (evt_edges),
        .evt_level      (evt_level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    // ---------------- PIO model ----------------
    logic       model_rst_n;
    logic       force_irq;
    logic [3:0] in_port;
    logic [3:0] in_prev;
    logic [3:0] edge_cap;
    logic [3:0] irq_mask;
    logic [3:0] edge_new;
    logic       unused_tb_s;

    assign edge_new    = in_port ^ in_prev;
    assign unused_tb_s = ^pio_writedata[31:4];

    // Any-edge capture, write-to-clear edge register, mask register, registered reads.
    always_ff @(posedge clk or negedge model_rst_n) begin
        if (!model_rst_n) begin
            in_prev      <= 4'd0;
            edge_cap     <= 4'd0;
            irq_mask     <= 4'd0;
            pio_readdata <= 32'd0;
        end else begin
            in_prev <= in_port;
            if (pio_chipselect && !pio_write_n && pio_address == 2'd3) begin
                edge_cap <= edge_new;
            end else begin
                edge_cap <= edge_cap | edge_new;
            end
            if (pio_chipselect && !pio_write_n && pio_address == 2'd2) begin
                irq_mask <= pio_writedata[3:0];
            end
            case (pio_address)
                2'd0:    pio_readdata <= {28'd0, in_port};
                2'd2:    pio_readdata <= {28'd0, irq_mask};
                2'd3:    pio_readdata <= {28'd0, edge_cap};
                default: pio_readdata <= 32'd0;
            endcase
        end
    end

    assign pio_irq = (|(edge_cap & irq_mask)) | force_irq;

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] in_val;
        logic [3:0] exp_edges;
        logic [3:0] exp_level;
    } ev_t;

    ev_t ev [6];
    int  keep [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_irq(input string name);
        int k;
        k = 0;
        while (!pio_irq && k < 60) begin
            step();
            k++;
        end
        n_checks++;
        if (!pio_irq) begin
            n_fail++;
            $display("FAIL %s: pio_irq never rose within 60 cycles", name);
        end
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!evt_valid && k < 60) begin
            step();
            k++;
        end
        n_checks++;
        if (!evt_valid) begin
            n_fail++;
            $display("FAIL %s: evt_valid never rose within 60 cycles", name);
        end
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy;

        // Event table: input pattern, expected captured edges, expected levels.
        ev[0] = '{4'b1011, 4'b0001, 4'b1011};
        ev[1] = '{4'b1001, 4'b0010, 4'b1001};
        ev[2] = '{4'b1101, 4'b0100, 4'b1101};
        ev[3] = '{4'b0101, 4'b1000, 4'b0101};
        ev[4] = '{4'b0100, 4'b0001, 4'b0100};
        ev[5] = '{4'b0110, 4'b0010, 4'b0110};
        keep  = '{1, 2, 3, 5};

        reset_n        = 1'b0;
        model_rst_n    = 1'b0;
        enable         = 1'b1;
        evt_ready      = 1'b0;
        clear_overflow = 1'b0;
        force_irq      = 1'b0;
        in_port        = 4'd0;
        repeat (3) step();
        model_rst_n = 1'b1;

        // ---- reset values ----
        chk("rst_cs",    32'(pio_chipselect), 32'd0);
        chk("rst_wn",    32'(pio_write_n),    32'd1);
        chk("rst_addr",  32'(pio_address),    32'd0);
        chk("rst_wd",    pio_writedata,       32'd0);
        chk("rst_valid", 32'(evt_valid),      32'd0);
        chk("rst_edges", 32'(evt_edges),      32'd0);
        chk("rst_level", 32'(evt_level),      32'd0);
        chk("rst_ovf",   32'(overflow),       32'd0);

        // ---- INIT write in the first cycle after release ----
        reset_n = 1'b1;
        step();
        chk("init_addr", 32'(pio_address),    32'd2);
        chk("init_wd",   pio_writedata,       32'h0000000F);
        chk("init_wn",   32'(pio_write_n),    32'd0);
        chk("init_cs",   32'(pio_chipselect), 32'd1);
        step();
        chk("idle_cs",    32'(pio_chipselect), 32'd0);
        chk("idle_wn",    32'(pio_write_n),    32'd1);
        chk("idle_addr",  32'(pio_address),    32'd0);
        chk("idle_valid", 32'(evt_valid),      32'd0);
        chk("mask_written", 32'(irq_mask),     32'hF);

        // ---- single event 0000 -> 0010 with exact cycle timing ----
        step();
        in_port = 4'b0010;
        wait_irq("t1_irq");                         // IDLE cycle 0
        step();                                     // cycle 1: RD_EDGE_A
        chk("t1_rde_addr", 32'(pio_address),    32'd3);
        chk("t1_rde_cs",   32'(pio_chipselect), 32'd1);
        chk("t1_rde_wn",   32'(pio_write_n),    32'd1);
        step();
        step();                                     // cycle 3: CLR
        chk("t1_clr_addr", 32'(pio_address),    32'd3);
        chk("t1_clr_wn",   32'(pio_write_n),    32'd0);
        chk("t1_clr_cs",   32'(pio_chipselect), 32'd1);
        chk("t1_clr_wd",   pio_writedata,       32'd0);
        step();                                     // cycle 4: RD_LVL_A
        chk("t1_irq_fall", 32'(pio_irq),        32'd0);
        chk("t1_rdl_addr", 32'(pio_address),    32'd0);
        chk("t1_rdl_cs",   32'(pio_chipselect), 32'd1);
        step();                                     // cycle 5
        chk("t1_valid_early", 32'(evt_valid),   32'd0);
        step();                                     // cycle 6
        chk("t1_valid", 32'(evt_valid), 32'd1);
        chk("t1_edges", 32'(evt_edges), 32'b0010);
        chk("t1_level", 32'(evt_level), 32'b0010);
        chk("t1_cap_cleared", 32'(edge_cap), 32'd0);
        pop_one();                                  // cycle 7
        chk("t1_pop_empty", 32'(evt_valid), 32'd0);

        // ---- hold-off: bit3 toggles five cycles after the first push ----
        step();
        step();
        step();                                     // cycle 10
        in_port = 4'b1010;
        step();                                     // cycle 11
        chk("t2_irq", 32'(pio_irq), 32'd1);
        busy = 0;
        for (int i = 0; i < 12; i++) begin          // cycles 11..22
            if (pio_chipselect) busy++;
            if (i < 11) step();
        end
        chk("t2_hold_quiet", 32'(busy), 32'd0);
        step();                                     // cycle 23
        chk("t2_resume_cs",   32'(pio_chipselect), 32'd1);
        chk("t2_resume_addr", 32'(pio_address),    32'd3);
        wait_valid("t2_valid");
        chk("t2_edges", 32'(evt_edges), 32'b1000);
        chk("t2_level", 32'(evt_level), 32'b1010);
        pop_one();
        chk("t2_pop_empty", 32'(evt_valid), 32'd0);

        // ---- overflow: five events with no consumer ----
        repeat (20) step();
        for (int i = 0; i < 5; i++) begin
            in_port = ev[i].in_val;
            repeat (25) step();
            if (i == 3) chk("t3_ovf_not_yet", 32'(overflow), 32'd0);
        end
        chk("t3_ovf_set",    32'(overflow),  32'd1);
        chk("t3_head_edges", 32'(evt_edges), 32'(ev[0].exp_edges));
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        chk("t3_ovf_clr", 32'(overflow), 32'd0);

        // Pop and push in the same cycle while full.
        in_port = ev[5].in_val;
        wait_irq("t3_irq");
        repeat (5) step();                          // RD_LVL_D cycle
        chk("t3_full_head_edges", 32'(evt_edges), 32'(ev[0].exp_edges));
        chk("t3_full_head_level", 32'(evt_level), 32'(ev[0].exp_level));
        pop_one();
        chk("t3_no_drop", 32'(overflow), 32'd0);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t3_pop%0d_valid", j), 32'(evt_valid), 32'd1);
            chk($sformatf("t3_pop%0d_edges", j), 32'(evt_edges), 32'(ev[keep[j]].exp_edges));
            chk($sformatf("t3_pop%0d_level", j), 32'(evt_level), 32'(ev[keep[j]].exp_level));
            pop_one();
        end
        chk("t3_drained", 32'(evt_valid), 32'd0);

        // ---- spurious interrupt: full pass, nothing pushed ----
        repeat (20) step();
        force_irq = 1'b1;
        step();
        force_irq = 1'b0;
        chk("sp_rde_cs",   32'(pio_chipselect), 32'd1);
        chk("sp_rde_addr", 32'(pio_address),    32'd3);
        step();
        step();
        chk("sp_clr_wn", 32'(pio_write_n), 32'd0);
        repeat (4) step();
        chk("sp_no_push", 32'(evt_valid), 32'd0);

        // ---- reset during CLR ----
        repeat (20) step();
        in_port = 4'b0010;                          // bit2 falls
        repeat (25) step();
        chk("t5_pre_valid", 32'(evt_valid), 32'd1);
        in_port = 4'b0011;                          // bit0 rises
        wait_irq("t5_irq");
        repeat (3) step();
        chk("t5_in_clr", 32'(pio_write_n), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_cs",    32'(pio_chipselect), 32'd0);
        chk("t5_rst_wn",    32'(pio_write_n),    32'd1);
        chk("t5_rst_addr",  32'(pio_address),    32'd0);
        chk("t5_rst_wd",    pio_writedata,       32'd0);
        chk("t5_rst_valid", 32'(evt_valid),      32'd0);
        chk("t5_rst_edges", 32'(evt_edges),      32'd0);
        step();
        step();
        reset_n = 1'b1;
        chk("t5_edge_pending", 32'(edge_cap), 32'b0001);
        step();
        chk("t5_reinit_addr", 32'(pio_address), 32'd2);
        chk("t5_reinit_wn",   32'(pio_write_n), 32'd0);
        wait_valid("t5_valid");
        chk("t5_edges", 32'(evt_edges), 32'b0001);
        chk("t5_level", 32'(evt_level), 32'b0011);
        pop_one();
        chk("t5_empty", 32'(evt_valid), 32'd0);

        // ---- enable low holds off servicing ----
        repeat (20) step();
        enable  = 1'b0;
        in_port = 4'b0111;
        busy = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (pio_chipselect) busy++;
        end
        chk("en_off_quiet", 32'(busy), 32'd0);
        enable = 1'b1;
        wait_valid("en_valid");
        chk("en_edges", 32'(evt_edges), 32'b0100);
        chk("en_level", 32'(evt_level), 32'b0111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rover_sw_event_ctrl.md
# rover_sw_event_ctrl

Interrupt-driven service controller for the rover's 4-bit switch PIO (Avalon-MM slave with data, irq_mask and edge_capture registers). After reset it programs the PIO interrupt mask. On each PIO interrupt it reads the edge-capture register, clears it, and reads the current switch levels. It then queues an {edges, levels} event into a small FIFO for the rover mode logic, with a hold-off window that debounces mechanical switch bounce.

## Interface
- IRQ_MASK, 4'hF: value written to PIO irq_mask (address 2) after reset.
- HOLDOFF, 16: idle cycles enforced after each service pass (0 = none).
- FIFO_DEPTH, 4: event FIFO entries, power of 2, ≥2.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- enable  in  1  1 = service interrupts; 0 = finish current pass then stay IDLE
- pio_address  out  2  PIO register address
- pio_chipselect  out  1  PIO select
- pio_write_n  out  1  PIO write strobe, active-low
- pio_writedata  out  32  PIO write data
- pio_readdata  in  32  PIO read data; registered every clk, read latency 1
- pio_irq  in  1  PIO interrupt (edge_capture & irq_mask)
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer pop
- evt_edges  out  4  head entry: captured edge bits
- evt_level  out  4  head entry: switch levels
- overflow  out  1  sticky: event dropped on full FIFO
- clear_overflow  in  1  synchronous clear of overflow

## Operation
- All PIO bus outputs are registered and decoded from state.
- Idle bus: chipselect=0, write_n=1, address=0, writedata=0.
- States:
  - INIT: write address 2, writedata={28'b0,IRQ_MASK}, chipselect=1, write_n=0 for one cycle -> IDLE.
  - IDLE: pio_irq=1 && enable=1 -> RD_EDGE_A; else stay.
  - RD_EDGE_A: address=3, chipselect=1, write_n=1 -> RD_EDGE_D.
  - RD_EDGE_D: address held at 3; capture pio_readdata[3:0] into edge_reg at end of cycle -> CLR.
  - CLR: address=3, writedata=0, chipselect=1, write_n=0 (clears all edge_capture bits) -> RD_LVL_A.
  - RD_LVL_A: address=0 read -> RD_LVL_D.
  - RD_LVL_D: capture pio_readdata[3:0] into lvl_reg; push {edge_reg, lvl_reg} -> HOLD (HOLDOFF>0) or IDLE.
  - HOLD: count HOLDOFF cycles with the bus idle; pio_irq is ignored -> IDLE.
- Push rules:
  - edge_reg==0 (spurious irq): no push.
  - FIFO full with no pop in the same cycle: entry dropped, overflow<=1.
  - Full with a simultaneous pop: push accepted, count unchanged.
- Pop occurs when evt_valid && evt_ready. evt_edges/evt_level always show the head entry; their value is don't-care when empty.
- overflow: set wins over clear_overflow in the same cycle.
- Pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits.
- Accepted limitation: an edge setting PIO edge_capture after the RD_EDGE_D sample and before the CLR write is lost.
- enable deasserted mid-pass: the pass completes, including push and hold-off.

## Timing
- Reset values:
  - pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0
  - evt_valid=0, evt_edges=0, evt_level=0, overflow=0
  - FIFO empty, state=INIT
- INIT write occurs in the first clk cycle after reset_n deasserts.
- Service latency: pio_irq high in IDLE cycle 0 -> RD_EDGE_A in cycle 1, CLR in cycle 3, push at end of cycle 5, evt_valid=1 in cycle 6.
- PIO irq falls by cycle 4.
- Pass length is 5 cycles plus HOLDOFF.
- Reset asserted mid-operation: immediate return to reset values. FIFO contents are discarded and INIT re-executes.

## Test plan
- Reset release, with a bench PIO model attached: cycle 1 shows address=2, writedata=0x0000000F, write_n=0; then bus idle; evt_valid=0.
- in_port 0000->0010: irq; evt_valid rises 6 cycles after irq with evt_edges=0010, evt_level=0010; PIO edge_capture reads 0 afterwards; pop with evt_ready=1 gives evt_valid=0.
- HOLDOFF=16, second toggle of bit3 five cycles after the first push: no bus activity until hold-off ends, then second event edges=1000.
- evt_ready=0, five separated events: 4 entries queued in order, 5th dropped, overflow=1. Pop plus push in the same cycle when full: count stays 4. clear_overflow pulse gives overflow=0.
- Spurious irq (pio_irq forced 1, edge_capture=0): full read/clear pass runs, no push, evt_valid stays 0.
- reset_n low during CLR: bus outputs at reset values in the same cycle, FIFO empty. After release INIT write repeats and a pending PIO edge is serviced normally.
